// File: rtl/spi_sector_read_ctrl_pkg.sv
// rtl/spi_sector_read_ctrl_pkg.sv - shared types and constants for the SPI sector read sequencer
package spi_sector_read_ctrl_pkg;

  // Sequencer states; the send states each carry exactly one byte in flight
  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CHECK,
    CMD,
    ADDR2,
    ADDR1,
    ADDR0,
    DATA,
    NEXT,
    ABORT,
    DONE
  } readState_t;

  // Flash READ opcode and the filler byte clocked out while reading data
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] DUMMY_BYTE = 8'h00;

  // Width of a down-counter able to hold the value n itself
  function automatic int cntWidth(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sector_byte_counter.sv
// rtl/sector_byte_counter.sv - per-sector data byte down-counter with last-byte flag
module sector_byte_counter #(
  parameter int SECTOR_BYTES = 512,
  parameter int CNT_W        = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic lastByte
);

  logic [CNT_W-1:0] byteCnt;

  // Reload at the start of every sector, count down once per received byte
  always_ff @(posedge clk) begin
    if (rst) begin
      byteCnt <= '0;
    end else if (load) begin
      byteCnt <= CNT_W'(SECTOR_BYTES);
    end else if (dec && (byteCnt != '0)) begin
      byteCnt <= byteCnt - CNT_W'(1);
    end
  end

  assign lastByte = (byteCnt == CNT_W'(1));

endmodule

// File: rtl/spi_sector_read_ctrl.sv
// rtl/spi_sector_read_ctrl.sv - multi-sector SPI flash READ sequencer into a local buffer
module spi_sector_read_ctrl
  import spi_sector_read_ctrl_pkg::*;
#(
  parameter int SECTOR_BYTES = 512,
  parameter int MEM_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       sectorCount,
  input  logic [23:0]      startAddr,
  output logic             initS,
  output logic             ldS,
  output logic             decS,
  output logic [7:0]       cntIn,
  input  logic             finished,
  output logic             spiCsN,
  output logic             spiStart,
  output logic [7:0]       spiTxData,
  input  logic             spiDone,
  input  logic [7:0]       spiRxData,
  output logic             memWe,
  output logic [MEM_W-1:0] memAddr,
  output logic [7:0]       memData,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int CNT_W = cntWidth(SECTOR_BYTES);

  readState_t  state;
  logic [23:0] flashAddr;
  logic        inFlight;
  logic        lastByte;
  logic        byteLoad;

  // Counter load happens on the same cycle the job is accepted
  assign ldS   = (state == IDLE) && start;
  assign cntIn = ldS ? sectorCount : 8'h00;

  // Buffer writes follow spiDone directly so data is captured with zero latency
  assign memWe   = (state == DATA) && spiDone;
  assign memData = memWe ? spiRxData : 8'h00;

  // The abort path may only release the sector counter once no byte is pending
  assign initS = (state == ABORT) && (!inFlight || spiDone);

  // Arm the byte counter as the last address byte completes
  assign byteLoad = (state == ADDR0) && spiDone;

  sector_byte_counter #(
    .SECTOR_BYTES (SECTOR_BYTES),
    .CNT_W        (CNT_W)
  ) u_byteCounter (
    .clk      (clk),
    .rst      (rst),
    .load     (byteLoad),
    .dec      (memWe),
    .lastByte (lastByte)
  );

  // Main sequencer: state, addresses and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flashAddr <= '0;
      memAddr   <= '0;
      spiCsN    <= 1'b1;
      spiStart  <= 1'b0;
      spiTxData <= 8'h00;
      inFlight  <= 1'b0;
      decS      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      spiStart <= 1'b0;
      decS     <= 1'b0;
      done     <= 1'b0;
      if (spiDone) begin
        inFlight <= 1'b0;
      end
      if (memWe) begin
        memAddr <= memAddr + MEM_W'(1);
      end

      case (state)
        IDLE: begin
          aborted <= 1'b0;
          if (start) begin
            flashAddr <= startAddr;
            memAddr   <= '0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end

        ABORT: begin
          if (initS) begin
            spiCsN  <= 1'b1;
            done    <= 1'b1;
            aborted <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          busy    <= 1'b0;
          aborted <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          if (abort) begin
            // A pending byte keeps inFlight set; ABORT waits on it
            state <= ABORT;
          end else begin
            case (state)
              LOAD: begin
                state <= CHECK;
              end

              CHECK: begin
                if (finished) begin
                  done  <= 1'b1;
                  state <= DONE;
                end else begin
                  spiCsN    <= 1'b0;
                  spiStart  <= 1'b1;
                  spiTxData <= CMD_READ;
                  inFlight  <= 1'b1;
                  state     <= CMD;
                end
              end

              CMD: begin
                if (spiDone) begin
                  spiStart  <= 1'b1;
                  spiTxData <= flashAddr[23:16];
                  inFlight  <= 1'b1;
                  state     <= ADDR2;
                end
              end

              ADDR2: begin
                if (spiDone) begin
                  spiStart  <= 1'b1;
                  spiTxData <= flashAddr[15:8];
                  inFlight  <= 1'b1;
                  state     <= ADDR1;
                end
              end

              ADDR1: begin
                if (spiDone) begin
                  spiStart  <= 1'b1;
                  spiTxData <= flashAddr[7:0];
                  inFlight  <= 1'b1;
                  state     <= ADDR0;
                end
              end

              ADDR0: begin
                if (spiDone) begin
                  spiStart  <= 1'b1;
                  spiTxData <= DUMMY_BYTE;
                  inFlight  <= 1'b1;
                  state     <= DATA;
                end
              end

              DATA: begin
                if (spiDone) begin
                  if (lastByte) begin
                    // Close the transaction and step to the next sector
                    spiCsN    <= 1'b1;
                    decS      <= 1'b1;
                    flashAddr <= flashAddr + 24'(SECTOR_BYTES);
                    state     <= NEXT;
                  end else begin
                    spiStart  <= 1'b1;
                    spiTxData <= DUMMY_BYTE;
                    inFlight  <= 1'b1;
                  end
                end
              end

              NEXT: begin
                state <= CHECK;
              end

              default: begin
                state <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sector_read_ctrl.sv
// tb/tb_spi_sector_read_ctrl.sv - randomized self-checking bench for spi_sector_read_ctrl
module tb_spi_sector_read_ctrl;

  localparam int SB = 4;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [7:0]    sectorCount;
  logic [23:0]   startAddr;
  logic          initS, ldS, decS;
  logic [7:0]    cntIn;
  logic          finished;
  logic          spiCsN, spiStart;
  logic [7:0]    spiTxData;
  logic          spiDone;
  logic [7:0]    spiRxData;
  logic          memWe;
  logic [MW-1:0] memAddr;
  logic [7:0]    memData;
  logic          busy, done, aborted;

  spi_sector_read_ctrl #(.SECTOR_BYTES(SB), .MEM_W(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sectorCount(sectorCount), .startAddr(startAddr),
    .initS(initS), .ldS(ldS), .decS(decS), .cntIn(cntIn), .finished(finished),
    .spiCsN(spiCsN), .spiStart(spiStart), .spiTxData(spiTxData),
    .spiDone(spiDone), .spiRxData(spiRxData),
    .memWe(memWe), .memAddr(memAddr), .memData(memData),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment: SPI engine, external sector counter, and observation logs
  int          pend = 0;
  int          delay = 1;
  logic [7:0]  rxCnt = 8'h40;
  logic [7:0]  secCnt = 8'h00;
  logic [7:0]  txLog[$];
  int          memAddrLog[$];
  logic [7:0]  memDataLog[$];
  int          ldCnt, ldVal, decCnt, initCnt, csFalls, protoErr;
  bit          doneSeen, doneAborted, doneBusy;
  int          doneTime, initTime, lastDoneTime;
  logic        prevCs = 1'b1;

  assign finished = (secCnt == 8'h00);

  initial begin
    spiDone   = 1'b0;
    spiRxData = 8'h00;
    forever begin
      @(negedge clk);
      spiDone   = 1'b0;
      spiRxData = 8'h00;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          spiDone      = 1'b1;
          spiRxData    = rxCnt;
          rxCnt        = rxCnt + 8'd1;
          lastDoneTime = int'($time);
        end
      end
      #2;
      if (rst) begin
        pend    = 0;
        spiDone = 1'b0;
        secCnt  = 8'h00;
      end else begin
        if (spiStart) begin
          if (spiCsN || pend > 0) protoErr++;
          txLog.push_back(spiTxData);
          pend = delay;
        end
        if (memWe) begin
          memAddrLog.push_back(int'(memAddr));
          memDataLog.push_back(memData);
        end
        if (ldS) begin
          ldCnt++;
          ldVal  = int'(cntIn);
          secCnt = cntIn;
        end
        if (initS) begin
          initCnt++;
          initTime = int'($time);
          if (!ldS) secCnt = 8'h00;
        end
        if (decS) begin
          decCnt++;
          if (!ldS && !initS) secCnt = secCnt - 8'd1;
        end
        if (prevCs && !spiCsN) csFalls++;
        if (done) begin
          doneSeen    = 1'b1;
          doneAborted = aborted;
          doneBusy    = busy;
          doneTime    = int'($time);
        end
      end
      prevCs = spiCsN;
    end
  end

  task automatic clearLogs();
    txLog.delete();
    memAddrLog.delete();
    memDataLog.delete();
    ldCnt = 0; ldVal = -1; decCnt = 0; initCnt = 0; csFalls = 0; protoErr = 0;
    doneSeen = 1'b0; doneAborted = 1'b0; doneBusy = 1'b0;
  endtask

  // mode 0: plain job, 1: start re-pulsed mid-job, 2: abort on 2nd data byte
  task automatic runJob(input logic [23:0] addr, input int n, input int dly, input int mode);
    logic [7:0]  expTx[$];
    logic [7:0]  rx0;
    logic [23:0] a;
    logic [7:0]  expData;
    int          t0;
    int          abortTime;
    bit          abortDone;
    int          lim;
    clearLogs();
    abortDone = 1'b0;
    abortTime = 0;
    delay     = dly;
    rx0       = rxCnt;
    @(negedge clk);
    sectorCount = n[7:0];
    startAddr   = addr;
    start       = 1'b1;
    t0          = int'($time);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && !doneSeen; i++) begin
      if (mode == 1) begin
        start       = (i == 10);
        sectorCount = n[7:0] + 8'd1;
        startAddr   = ~addr;
      end
      if (mode == 2) begin
        if (!abortDone && txLog.size() == 6) begin
          abort     = 1'b1;
          abortDone = 1'b1;
          abortTime = int'($time);
        end else begin
          abort = 1'b0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    checkVal("done_seen", 32'(doneSeen), 32'd1);
    checkVal("done_aborted", 32'(doneAborted), 32'(mode == 2));
    checkVal("done_busy", 32'(doneBusy), 32'd1);
    checkVal("lds_count", 32'(ldCnt), 32'd1);
    checkVal("lds_value", 32'(ldVal), 32'(n));
    checkVal("spi_protocol", 32'(protoErr), 32'd0);
    if (mode == 2) begin
      checkVal("abort_tx_count", 32'(txLog.size()), 32'd6);
      checkVal("abort_we_count", 32'(memAddrLog.size()), 32'd1);
      checkVal("abort_init_count", 32'(initCnt), 32'd1);
      checkVal("abort_waited_done", 32'(lastDoneTime > abortTime), 32'd1);
      checkVal("abort_init_after_done", 32'(initTime >= lastDoneTime), 32'd1);
      checkVal("abort_done_after_init", 32'(doneTime > initTime), 32'd1);
      checkVal("abort_dec_count", 32'(decCnt), 32'd0);
    end else begin
      for (int s = 0; s < n; s++) begin
        a = addr + 24'(s * SB);
        expTx.push_back(8'h03);
        expTx.push_back(a[23:16]);
        expTx.push_back(a[15:8]);
        expTx.push_back(a[7:0]);
        for (int j = 0; j < SB; j++) expTx.push_back(8'h00);
      end
      checkVal("tx_count", 32'(txLog.size()), 32'(expTx.size()));
      lim = (txLog.size() < expTx.size()) ? txLog.size() : expTx.size();
      for (int i = 0; i < lim; i++) checkVal($sformatf("tx_byte%0d", i), 32'(txLog[i]), 32'(expTx[i]));
      checkVal("we_count", 32'(memAddrLog.size()), 32'(n * SB));
      lim = (memAddrLog.size() < n * SB) ? memAddrLog.size() : n * SB;
      for (int k = 0; k < lim; k++) begin
        expData = rx0 + 8'((k / SB) * (4 + SB) + 4 + (k % SB));
        checkVal($sformatf("mem_addr%0d", k), 32'(memAddrLog[k]), 32'(k));
        checkVal($sformatf("mem_data%0d", k), 32'(memDataLog[k]), 32'(expData));
      end
      checkVal("dec_count", 32'(decCnt), 32'(n));
      checkVal("cs_windows", 32'(csFalls), 32'(n));
      checkVal("init_count", 32'(initCnt), 32'd0);
      if (n == 0) checkVal("zero_done_latency", 32'(doneTime - t0), 32'd32);
    end
    @(negedge clk);
    #3;
    checkVal("idle_busy", 32'(busy), 32'd0);
    checkVal("idle_cs", 32'(spiCsN), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    sectorCount = 8'h00;
    startAddr   = 24'h000000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    checkVal("rst_cs", 32'(spiCsN), 32'd1);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_done", 32'(done), 32'd0);
    checkVal("rst_aborted", 32'(aborted), 32'd0);
    checkVal("rst_spistart", 32'(spiStart), 32'd0);
    checkVal("rst_txdata", 32'(spiTxData), 32'd0);
    checkVal("rst_memwe", 32'(memWe), 32'd0);
    checkVal("rst_memaddr", 32'(memAddr), 32'd0);
    checkVal("rst_ctrl", 32'({ldS, decS, initS}), 32'd0);

    runJob(24'h001000, 2, 1, 0);
    runJob(24'h00ABCD, 0, 1, 0);
    runJob(24'hFFFFFC, 2, 2, 0);
    runJob(24'h002000, 3, 5, 2);
    runJob(24'h123456, 2, 1, 1);

    // Reset in the middle of a data phase
    clearLogs();
    delay = 2;
    @(negedge clk);
    sectorCount = 8'd2;
    startAddr   = 24'h00F000;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500 && memAddrLog.size() < 2; i++) @(negedge clk);
    checkVal("rstmid_reached_data", 32'(memAddrLog.size() >= 2), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    checkVal("rstmid_cs", 32'(spiCsN), 32'd1);
    checkVal("rstmid_busy", 32'(busy), 32'd0);
    checkVal("rstmid_memwe", 32'(memWe), 32'd0);
    checkVal("rstmid_spistart", 32'(spiStart), 32'd0);
    checkVal("rstmid_memaddr", 32'(memAddr), 32'd0);
    runJob(24'h00F000, 2, 1, 0);

    for (int r = 0; r < 4; r++) begin
      runJob(24'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_sector_read_ctrl.md
# spi_sector_read_ctrl

Sequencer for multi-sector SPI flash reads in the MCU SPI subsystem. A job is a start flash address plus a sector count. For each sector, the block opens a READ (0x03) transaction on the SPI byte engine and streams SECTOR_BYTES bytes into the local buffer memory. It drives the load, decrement and init controls of the external 8-bit sector counter and uses that counter's `finished` flag as the loop condition.

## Interface
- SECTOR_BYTES, 512: bytes per sector; power of two, at least 2.
- MEM_W, 16: buffer write-address width.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  cancel the current job; ignored in IDLE.
- sectorCount  in  8  number of sectors for the job.
- startAddr  in  24  flash byte address of the first sector.
- initS / ldS / decS  out  1 each  sector counter controls, one-cycle pulses.
- cntIn  out  8  sector counter load value; equals sectorCount while ldS is high.
- finished  in  1  sector counter is zero.
- spiCsN  out  1  flash chip select, active low.
- spiStart  out  1  one-cycle byte-exchange request.
- spiTxData  out  8  byte to send; valid with spiStart.
- spiDone  in  1  byte exchange complete, one-cycle pulse.
- spiRxData  in  8  received byte; valid while spiDone is high.
- memWe  out  1  buffer write strobe.
- memAddr  out  MEM_W  buffer write address.
- memData  out  8  buffer write data.
- busy  out  1  a job is active.
- done  out  1  one-cycle pulse when a job ends.
- aborted  out  1  qualifies done: the job was cancelled.

## Operation
- States: IDLE, LOAD, CHECK, CMD, ADDR2, ADDR1, ADDR0, DATA, NEXT, ABORT, DONE.
- IDLE: on start, pulse ldS with cntIn = sectorCount, latch startAddr into flashAddr, clear memAddr to 0 and go to LOAD.
- LOAD: one cycle so the counter value settles. Then CHECK.
- CHECK: if finished, go to DONE. Otherwise drive spiCsN = 0 and go to CMD.
- CMD: send 0x03.
- ADDR2 / ADDR1 / ADDR0: send flashAddr[23:16], [15:8], [7:0] in that order.
- Each send state pulses spiStart for one cycle on entry, waits for spiDone, then moves to the next state.
- DATA:
  - Exchange 0x00 dummy bytes, SECTOR_BYTES of them in total, counted by byteCnt.
  - On each spiDone: memWe = 1, memData = spiRxData, memAddr = current value. memAddr then increments, wrapping mod 2^MEM_W.
  - The last byte moves the FSM to NEXT.
- NEXT: spiCsN = 1, pulse decS, flashAddr += SECTOR_BYTES (wraps mod 2^24). Then CHECK.
- The rx bytes received during command and address bytes are discarded.
- Abort:
  - abort in LOAD..NEXT goes to ABORT.
  - If a byte is in flight (spiStart issued, spiDone not yet seen), ABORT waits for that spiDone. That final byte is not written.
  - ABORT then sets spiCsN = 1, pulses initS and goes to DONE with aborted latched.
- DONE: done = 1 for one cycle, aborted valid that cycle. Then IDLE.
- start during busy is ignored.
- abort and start together in IDLE: start wins.

## Timing
- Reset values: state IDLE, spiCsN = 1, busy = 0. Every other output is 0, as are flashAddr, memAddr and byteCnt.
- busy is 1 from the cycle after start is accepted through the DONE cycle inclusive.
- Zero sectors, start at cycle t:
  - t: ldS pulse.
  - t+1: LOAD.
  - t+2: CHECK.
  - t+3: DONE, done = 1.
  - t+4: IDLE.
  - spiCsN never falls.
- spiCsN falls in the CHECK→CMD cycle. The first spiStart is in the first CMD cycle.
- spiStart for the next byte comes no earlier than the cycle after the previous spiDone. At most one byte is ever in flight.
- memWe is combinational with spiDone in DATA, so zero latency.
- spiCsN rises in NEXT, at least one full cycle high between sectors.
- Reset mid-operation: all registers take their reset values on the next edge. No initS is pulsed; the counter is reset by the shared rst.

## Structure
- Shared SPI package holds:
  - state encoding (enum);
  - CMD_READ = 8'h03;
  - DUMMY_BYTE = 8'h00.
- One sub-module, sector_byte_counter:
  - loadable down-counter of width log2(SECTOR_BYTES)+1;
  - provides the last-byte flag.
- The FSM, flashAddr and memAddr registers stay in the top level.

## Test plan
- SECTOR_BYTES = 4, sectorCount = 2, startAddr = 24'h001000, spi model echoes incrementing rx:
  - two CS-low windows;
  - tx sequences 03 00 10 00 / 03 00 10 04;
  - 8 memWe at memAddr 0..7;
  - decS twice, then done = 1 with aborted = 0.
- sectorCount = 0: done exactly 3 cycles after start; no spiStart; spiCsN stays 1.
- startAddr = 24'hFFFFFC, SECTOR_BYTES = 4, 2 sectors: second address bytes are 00 00 00.
- abort during the 2nd data byte with spiDone delayed 5 cycles:
  - no memWe for that byte;
  - spiCsN = 1 after spiDone;
  - initS pulse, then done with aborted = 1.
- start re-pulsed while busy: no second ldS; job completes unchanged.
- rst asserted mid-DATA: next cycle spiCsN = 1, busy = 0, memWe = 0; a new start then runs cleanly.
